// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with programmable modulus, wrap or saturate at the
// boundaries, clear/load/enable priority, terminal count and event pulses.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MOD      = 16,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);
    localparam bit               SAT     = (SAT_MODE != 0);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 1..16");
    end
    if (MOD < 2 || 64'(MOD) > (64'(1) << WIDTH)) begin : g_bad_mod
        $error("param_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_load_err;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_load_err_nxt;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_ok;

    assign w_at_max  = (r_cnt == CNT_MAX);
    assign w_at_zero = (r_cnt == '0);
    // Compared at 32 bits so MOD == 2**WIDTH accepts every load value.
    assign w_load_ok = (32'(load_val) < MOD);

    // Next-state: clr > load > en > hold; pulses default low every edge.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_ovf_nxt      = 1'b0;
        w_load_err_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (load) begin
            if (w_load_ok) begin
                w_cnt_nxt = load_val;
            end else begin
                w_cnt_nxt      = CNT_MAX;
                w_load_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (!w_at_max) begin
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end else begin
                    w_ovf_nxt = 1'b1;
                    w_cnt_nxt = SAT ? r_cnt : '0;
                end
            end else begin
                if (!w_at_zero) begin
                    w_cnt_nxt = r_cnt - WIDTH'(1);
                end else begin
                    w_ovf_nxt = 1'b1;
                    w_cnt_nxt = SAT ? r_cnt : CNT_MAX;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Same-cycle terminal count so a following stage can use it as its enable.
    assign tc       = en & ~clr & ~load & ((up & w_at_max) | (~up & w_at_zero));
    assign cnt      = r_cnt;
    assign ovf      = r_ovf;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: wrap, saturate, load range,
// async reset, direction changes and a two-stage chain.
module tb_param_updown_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       ovf;
        logic       lerr;
        logic [3:0] aux;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [1:0] c0;
    logic       tc0, ovf0, le0;
    logic [3:0] c1, c2;
    logic       tc1, ovf1, le1, tc2, ovf2, le2;

    logic       ch_en = 1'b0, ch_clr = 1'b0, ch_load = 1'b0;
    logic [3:0] ch_lv = 4'd0;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, lo_ovf, lo_le, hi_tc, hi_ovf, hi_le;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(2), .MOD(4), .SAT_MODE(0)) d0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[1:0]), .cnt(c0), .tc(tc0), .ovf(ovf0), .load_err(le0));

    param_updown_counter #(.WIDTH(4), .MOD(10), .SAT_MODE(0)) d1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .cnt(c1), .tc(tc1), .ovf(ovf1), .load_err(le1));

    param_updown_counter #(.WIDTH(4), .MOD(10), .SAT_MODE(1)) d2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .cnt(c2), .tc(tc2), .ovf(ovf2), .load_err(le2));

    param_updown_counter #(.WIDTH(4), .MOD(10), .SAT_MODE(0)) u_lo (
        .clk(clk), .rst(rst), .en(ch_en), .up(1'b1), .clr(ch_clr), .load(ch_load),
        .load_val(ch_lv), .cnt(lo_cnt), .tc(lo_tc), .ovf(lo_ovf), .load_err(lo_le));

    param_updown_counter #(.WIDTH(4), .MOD(10), .SAT_MODE(0)) u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .clr(ch_clr), .load(ch_load),
        .load_val(ch_lv), .cnt(hi_cnt), .tc(hi_tc), .ovf(hi_ovf), .load_err(hi_le));

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; up = 1'b0; clr = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({2'b00, c0} !== 4'd0 || c1 !== 4'd0 || c2 !== 4'd0 || lo_cnt !== 4'd0 || hi_cnt !== 4'd0)
            $display("FAIL reset_cnt: got c0=%0d c1=%0d c2=%0d lo=%0d hi=%0d, expected all 0",
                     c0, c1, c2, lo_cnt, hi_cnt);
        else n_pass++;
        n_checks++;
        if ({ovf0, ovf1, ovf2, le0, le1, le2} !== 6'b0)
            $display("FAIL reset_pulses: got ovf=%b%b%b lerr=%b%b%b, expected all 0",
                     ovf0, ovf1, ovf2, le0, le1, le2);
        else n_pass++;
        // cnt=0 with en=1, up=0 must already show terminal count
        n_checks++;
        if (tc1 !== 1'b1) $display("FAIL reset_tc: got tc=%b, expected 1", tc1);
        else n_pass++;
        en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_wrap_up();
        int   ec[6];
        int   eo[6];
        int   et[6];
        exp_t e;
        ec = '{1, 2, 3, 0, 1, 2};
        eo = '{0, 0, 0, 1, 0, 0};
        et = '{0, 0, 0, 1, 0, 0};
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (tc0 !== 1'(et[i])) $display("FAIL wrap_up_tc[%0d]: got %b, expected %0d", i, tc0, et[i]);
            else n_pass++;
            sb.push_back('{cnt: 4'(ec[i]), ovf: 1'(eo[i]), lerr: 1'b0, aux: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({2'b00, c0} !== e.cnt || ovf0 !== e.ovf || le0 !== e.lerr)
                $display("FAIL wrap_up[%0d]: got cnt=%0d ovf=%b lerr=%b, expected cnt=%0d ovf=%b lerr=%b",
                         i, c0, ovf0, le0, e.cnt, e.ovf, e.lerr);
            else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        int   ec[5];
        int   eo[5];
        int   et[5];
        exp_t e;
        ec = '{2, 1, 0, 9, 8};
        eo = '{0, 0, 0, 1, 0};
        et = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            load = (i == 0); lv = 4'd2; en = (i != 0); up = 1'b0;
            #1;
            n_checks++;
            if (tc1 !== 1'(et[i])) $display("FAIL down_tc[%0d]: got %b, expected %0d", i, tc1, et[i]);
            else n_pass++;
            sb.push_back('{cnt: 4'(ec[i]), ovf: 1'(eo[i]), lerr: 1'b0, aux: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (c1 !== e.cnt || ovf1 !== e.ovf || le1 !== e.lerr)
                $display("FAIL down[%0d]: got cnt=%0d ovf=%b lerr=%b, expected cnt=%0d ovf=%b lerr=%b",
                         i, c1, ovf1, le1, e.cnt, e.ovf, e.lerr);
            else n_pass++;
        end
        en = 1'b0; load = 1'b0;
    endtask

    task automatic test_saturate();
        int   ec[6];
        int   eo[6];
        int   et[6];
        exp_t e;
        ec = '{8, 9, 9, 9, 9, 8};
        eo = '{0, 0, 1, 1, 1, 0};
        et = '{0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            load = (i == 0); lv = 4'd8; en = (i != 0); up = (i != 5);
            #1;
            n_checks++;
            if (tc2 !== 1'(et[i])) $display("FAIL sat_tc[%0d]: got %b, expected %0d", i, tc2, et[i]);
            else n_pass++;
            sb.push_back('{cnt: 4'(ec[i]), ovf: 1'(eo[i]), lerr: 1'b0, aux: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (c2 !== e.cnt || ovf2 !== e.ovf || le2 !== e.lerr)
                $display("FAIL sat[%0d]: got cnt=%0d ovf=%b lerr=%b, expected cnt=%0d ovf=%b lerr=%b",
                         i, c2, ovf2, le2, e.cnt, e.ovf, e.lerr);
            else n_pass++;
        end
        en = 1'b0; load = 1'b0;
    endtask

    task automatic test_load_err();
        // columns: clr load en up load_val | exp cnt ovf lerr tc
        int   tclr[7], tld[7], ten[7], tup[7], tlv[7];
        int   ec[7], eo[7], el[7], et[7];
        exp_t e;
        tclr = '{0, 0, 0, 0, 0, 0, 1};
        tld  = '{1, 0, 1, 1, 0, 1, 1};
        ten  = '{0, 0, 0, 0, 1, 1, 1};
        tup  = '{1, 1, 1, 1, 1, 0, 1};
        tlv  = '{12, 0, 10, 9, 0, 3, 12};
        ec   = '{9, 9, 9, 9, 0, 3, 0};
        eo   = '{0, 0, 0, 0, 1, 0, 0};
        el   = '{1, 0, 1, 0, 0, 0, 0};
        et   = '{0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            clr = 1'(tclr[i]); load = 1'(tld[i]); en = 1'(ten[i]); up = 1'(tup[i]); lv = 4'(tlv[i]);
            #1;
            n_checks++;
            if (tc1 !== 1'(et[i])) $display("FAIL load_tc[%0d]: got %b, expected %0d", i, tc1, et[i]);
            else n_pass++;
            sb.push_back('{cnt: 4'(ec[i]), ovf: 1'(eo[i]), lerr: 1'(el[i]), aux: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (c1 !== e.cnt || ovf1 !== e.ovf || le1 !== e.lerr)
                $display("FAIL load[%0d]: got cnt=%0d ovf=%b lerr=%b, expected cnt=%0d ovf=%b lerr=%b",
                         i, c1, ovf1, le1, e.cnt, e.ovf, e.lerr);
            else n_pass++;
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{cnt: 4'(i + 1), ovf: 1'b0, lerr: 1'b0, aux: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (c1 !== e.cnt) $display("FAIL arst_count[%0d]: got %0d, expected %0d", i, c1, e.cnt);
            else n_pass++;
        end
        #2; rst = 1'b0; up = 1'b0; #1;
        n_checks++;
        if (c1 !== 4'd0 || ovf1 !== 1'b0 || tc1 !== 1'b1)
            $display("FAIL arst_mid: got cnt=%0d ovf=%b tc=%b, expected cnt=0 ovf=0 tc=1", c1, ovf1, tc1);
        else n_pass++;
        #2; rst = 1'b1; up = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (c1 !== 4'd1) $display("FAIL arst_release: got %0d, expected 1", c1);
        else n_pass++;
        // an in-flight ovf pulse is dropped by reset without a clock edge
        en = 1'b0; load = 1'b1; lv = 4'd9; @(posedge clk); #1;
        load = 1'b0; en = 1'b1; @(posedge clk); #1;
        n_checks++;
        if (c1 !== 4'd0 || ovf1 !== 1'b1) $display("FAIL arst_pre: got cnt=%0d ovf=%b, expected cnt=0 ovf=1", c1, ovf1);
        else n_pass++;
        #2; rst = 1'b0; #1;
        n_checks++;
        if (ovf1 !== 1'b0 || c1 !== 4'd0) $display("FAIL arst_ovf: got cnt=%0d ovf=%b, expected cnt=0 ovf=0", c1, ovf1);
        else n_pass++;
        en = 1'b0; #2; rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int   tup[5];
        int   e0[5], o0[5], e1[5], o1[5], e2[5], o2[5];
        exp_t e;
        tup = '{0, 1, 1, 0, 0};
        e0 = '{3, 0, 1, 0, 3}; o0 = '{1, 1, 0, 0, 1};
        e1 = '{9, 0, 1, 0, 9}; o1 = '{1, 1, 0, 0, 1};
        e2 = '{0, 1, 2, 1, 0}; o2 = '{1, 0, 0, 0, 0};
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up = 1'(tup[i]);
            sb.push_back('{cnt: 4'(e0[i]), ovf: 1'(o0[i]), lerr: 1'b0, aux: 4'd0});
            sb.push_back('{cnt: 4'(e1[i]), ovf: 1'(o1[i]), lerr: 1'b0, aux: 4'd1});
            sb.push_back('{cnt: 4'(e2[i]), ovf: 1'(o2[i]), lerr: 1'b0, aux: 4'd2});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({2'b00, c0} !== e.cnt || ovf0 !== e.ovf)
                $display("FAIL b2b_w2[%0d]: got cnt=%0d ovf=%b, expected cnt=%0d ovf=%b", i, c0, ovf0, e.cnt, e.ovf);
            else n_pass++;
            e = sb.pop_front();
            n_checks++;
            if (c1 !== e.cnt || ovf1 !== e.ovf)
                $display("FAIL b2b_wrap[%0d]: got cnt=%0d ovf=%b, expected cnt=%0d ovf=%b", i, c1, ovf1, e.cnt, e.ovf);
            else n_pass++;
            e = sb.pop_front();
            n_checks++;
            if (c2 !== e.cnt || ovf2 !== e.ovf)
                $display("FAIL b2b_sat[%0d]: got cnt=%0d ovf=%b, expected cnt=%0d ovf=%b", i, c2, ovf2, e.cnt, e.ovf);
            else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_chain();
        exp_t e;
        ch_en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            sb.push_back('{cnt: 4'(k % 10), ovf: ((k % 10) == 0), lerr: 1'b0, aux: 4'(k / 10)});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (lo_cnt !== e.cnt || hi_cnt !== e.aux || lo_ovf !== e.ovf || hi_ovf !== 1'b0)
                $display("FAIL chain[%0d]: got lo=%0d hi=%0d lo_ovf=%b hi_ovf=%b, expected lo=%0d hi=%0d lo_ovf=%b hi_ovf=0",
                         k, lo_cnt, hi_cnt, lo_ovf, hi_ovf, e.cnt, e.aux, e.ovf);
            else n_pass++;
        end
        ch_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_wrap();
        test_saturate();
        test_load_err();
        test_async_reset();
        test_back_to_back();
        test_chain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's fixed 2-bit binary counter. Provides a WIDTH-bit up/down counter with programmable modulus, synchronous clear, parallel load, count enable, and a selectable wrap or saturate mode. It also flags terminal count and overflow/underflow events. It is the general counter for the encrypt/decrypt datapath: round counters, byte indices and key-schedule step counters.

Parameters:
WIDTH, 4, counter width in bits (1..16)
MOD, 16, modulus; count range is 0..MOD-1; constraint 2 <= MOD <= 2**WIDTH
SAT_MODE, 0, 0 = wrap at the boundaries, 1 = saturate at the boundaries

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
en  input  1  count enable
up  input  1  direction; 1 = increment, 0 = decrement
clr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
cnt  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational)
ovf  output  1  one-cycle boundary-event pulse (registered)
load_err  output  1  one-cycle pulse: load_val was out of range (registered)

Behaviour:
- Reset (rst=0, asynchronous, independent of clk): cnt=0, ovf=0, load_err=0. Release is synchronous to the next rising clk edge. The first update occurs on the first rising edge with rst=1.
- Per-edge priority: clr > load > en > hold.
- clr=1: cnt<=0. ovf<=0, load_err<=0. load and en are ignored that cycle.
- load=1 (clr=0):
  - If load_val < MOD: cnt<=load_val, load_err<=0.
  - Otherwise: cnt<=MOD-1, load_err<=1 for one cycle.
  - ovf<=0 in both cases. en is ignored.
- en=1, up=1 (no clr/load):
  - cnt<MOD-1: cnt<=cnt+1, ovf<=0.
  - cnt==MOD-1, SAT_MODE=0: cnt<=0, ovf<=1.
  - cnt==MOD-1, SAT_MODE=1: cnt holds, ovf<=1.
- en=1, up=0 (no clr/load):
  - cnt>0: cnt<=cnt-1, ovf<=0.
  - cnt==0, SAT_MODE=0: cnt<=MOD-1, ovf<=1.
  - cnt==0, SAT_MODE=1: cnt holds, ovf<=1.
- en=0 (no clr/load): cnt holds; ovf<=0, load_err<=0.
- ovf and load_err are single-cycle pulses. They are cleared on every edge that does not generate them. Back-to-back boundary events produce ovf=1 on consecutive cycles (saturate mode with en held at the boundary).
- tc = en & ~clr & ~load & ((up & cnt==MOD-1) | (~up & cnt==0)). It is purely combinational from the current inputs and cnt, with no added latency, so a downstream stage can chain counters by feeding tc into the next stage's en.
- Latency: cnt reflects the operation one edge after it is sampled.
- Direction change while en=1 takes effect on the same edge; there is no turnaround cycle.
- Arithmetic: the internal compare/increment uses WIDTH bits. Non-power-of-two MOD must never produce values >= MOD, including after load. When MOD == 2**WIDTH, the natural wrap is equivalent to the modulo wrap.
- Reset asserted mid-count, or in the same cycle as clr/load/en: the reset wins immediately. All outputs go to their reset values, and tc evaluates with cnt=0.
- X-safety: en, up, clr and load must not drive cnt to X while rst=0.

Test Plan:
1. WIDTH=2, MOD=4, SAT_MODE=0, en=1, up=1 for 6 edges from reset -> cnt 1,2,3,0,1,2. tc=1 while cnt=3. ovf=1 in exactly the cycle after cnt 3->0.
2. WIDTH=4, MOD=10, SAT_MODE=0, load 2, then up=0, en=1 for 4 edges -> cnt 2,1,0,9,8. ovf pulses once after 0->9. tc=1 while cnt=0.
3. WIDTH=4, MOD=10, SAT_MODE=1, load 8, en=1, up=1 for 4 edges -> cnt 9,9,9,9. ovf=1 on the last three edges. Then up=0 -> cnt 8, ovf=0.
4. MOD=10, load=1 with load_val=12 -> cnt=9, load_err=1 for one cycle. clr=1 with load=1 and en=1 in the same cycle -> cnt=0, load_err=0.
5. Count to 5 with en=1, then pull rst low between edges -> cnt=0 and ovf=0 immediately, without a clk edge. Release rst; the next edge with en=1, up=1 -> cnt=1.
6. Chain two instances (MOD=10 each, low tc -> high en), run 25 up-counts -> low=5, high=2. The high ovf stays at 0 throughout.
